// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the instruction word layout (field bit positions), the opcode and
// register-name constants, and the fetch FSM state type.
package instruction_fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 28;
    localparam int DELAY_W = 24;

    // Instruction word layout: {opcode, dest, src1, src0}; the immediate
    // overlays src1/src0, and the NOP delay payload overlays dest/src1/src0.
    localparam int OP_HI      = 27;
    localparam int OP_LO      = 24;
    localparam int DST_HI     = 23;
    localparam int DST_LO     = 16;
    localparam int SRC1_HI    = 15;
    localparam int SRC1_LO    = 8;
    localparam int SRC0_HI    = 7;
    localparam int SRC0_LO    = 0;
    localparam int IMM_HI     = 15;
    localparam int IMM_LO     = 0;
    localparam int PAYLOAD_HI = 23;
    localparam int PAYLOAD_LO = 0;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LED = 4'h7;

    // Register names
    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;
    localparam logic [7:0] R4 = 8'd4;
    localparam logic [7:0] R5 = 8'd5;
    localparam logic [7:0] R6 = 8'd6;
    localparam logic [7:0] R7 = 8'd7;

    typedef enum logic {FETCH = 1'b0, DELAY = 1'b1} fetch_state_e;

    function automatic logic is_nop(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO] == OP_NOP;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, downstream stall and branch redirect,
// and the decoded instruction fields issued downstream.
//   master : the fetch unit (drives oAddress and the issued fields)
//   slave  : ROM + downstream consumer (drives iInstruction, iStall, branch)
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic [ADDR_W-1:0]  oAddress;
    logic [INSTR_W-1:0] iInstruction;
    logic               iStall;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;
    logic               oValid;
    logic [3:0]         oOperation;
    logic [7:0]         oDestination;
    logic [7:0]         oSourceAddr1;
    logic [7:0]         oSourceAddr0;
    logic [15:0]        oImmediate;

    modport master (
        output oAddress, oValid, oOperation, oDestination,
               oSourceAddr1, oSourceAddr0, oImmediate,
        input  iInstruction, iStall, iBranchTaken, iBranchTarget
    );

    modport slave (
        input  oAddress, oValid, oOperation, oDestination,
               oSourceAddr1, oSourceAddr0, oImmediate,
        output iInstruction, iStall, iBranchTaken, iBranchTarget
    );
endinterface

// File: rtl/instruction_fetch_nop_delay_counter.sv
// Loadable down-counter used to burn the cycles requested by a NOP.
//   clk, rst_n  : clock, async active-low reset (clears the count)
//   load_i      : load load_val_i (has priority over decrement)
//   load_val_i  : value to load
//   dec_i       : decrement by one (saturates at zero)
//   zero_o      : count is zero
module nop_delay_counter
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DELAY_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);
    logic [DELAY_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (load_i)
            count_q <= load_val_i;
        else if (dec_i && count_q != '0)
            count_q <= count_q - DELAY_W'(1);
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads a combinational ROM at the PC, registers the
// decoded fields downstream, stalls on request, honours branch redirects and
// spends NOP payload cycles idle.
//   clk, rst_n : clock, async active-low reset
//   bus        : instruction_fetch_if.master (ROM address/data, stall,
//                branch redirect, issued fields + oValid)
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_if.master  bus
);
    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q;
    logic [3:0]         op_q;
    logic [7:0]         dst_q, src1_q, src0_q;
    logic [15:0]        imm_q;

    logic               nop;
    logic [DELAY_W-1:0] payload;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [DELAY_W-1:0] cnt_load_val;

    assign nop     = is_nop(bus.iInstruction);
    assign payload = bus.iInstruction[PAYLOAD_HI:PAYLOAD_LO];
    assign pc_d    = pc_q + ADDR_W'(1);   // wraps FFFF -> 0000

    // The NOP cycle itself counts as one of the N+1 idle cycles, so DELAY
    // only has to cover N cycles: load N-1 and leave once the count is zero.
    // N=0 never enters DELAY.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        if (bus.iBranchTaken) begin
            cnt_load = 1'b1;
        end else if (!bus.iStall) begin
            if (state_q == FETCH && nop) begin
                cnt_load     = 1'b1;
                cnt_load_val = (payload == '0) ? '0 : payload - DELAY_W'(1);
            end else if (state_q == DELAY && !cnt_zero) begin
                cnt_dec = 1'b1;
            end
        end
    end

    nop_delay_counter u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            op_q    <= '0;
            dst_q   <= '0;
            src1_q  <= '0;
            src0_q  <= '0;
            imm_q   <= '0;
        end else if (bus.iBranchTaken) begin
            // Redirect wins over stall and any pending NOP delay.
            state_q <= FETCH;
            pc_q    <= bus.iBranchTarget;
            valid_q <= 1'b0;
        end else if (!bus.iStall) begin
            case (state_q)
                FETCH: begin
                    pc_q <= pc_d;
                    if (nop) begin
                        valid_q <= 1'b0;
                        if (payload != '0)
                            state_q <= DELAY;
                    end else begin
                        valid_q <= 1'b1;
                        op_q    <= bus.iInstruction[OP_HI:OP_LO];
                        dst_q   <= bus.iInstruction[DST_HI:DST_LO];
                        src1_q  <= bus.iInstruction[SRC1_HI:SRC1_LO];
                        src0_q  <= bus.iInstruction[SRC0_HI:SRC0_LO];
                        imm_q   <= bus.iInstruction[IMM_HI:IMM_LO];
                    end
                end
                DELAY: begin
                    valid_q <= 1'b0;
                    if (cnt_zero)
                        state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign bus.oAddress     = pc_q;
    assign bus.oValid       = valid_q;
    assign bus.oOperation   = op_q;
    assign bus.oDestination = dst_q;
    assign bus.oSourceAddr1 = src1_q;
    assign bus.oSourceAddr0 = src0_q;
    assign bus.oImmediate   = imm_q;
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'd0: program counter value loaded on reset.
REQ-002 Clock  input  1  single clock, all state on rising edge.
REQ-003 Reset  input  1  reset, asynchronous, active-low.
REQ-004 oAddress  output  16  program counter, drives instruction ROM address (ROM is combinational).
REQ-005 iInstruction  input  28  ROM word for oAddress, same cycle.
REQ-006 iStall  input  1  downstream not ready; hold issued instruction.
REQ-007 iBranchTaken  input  1  downstream redirect request.
REQ-008 iBranchTarget  input  16  redirect address, valid with iBranchTaken.
REQ-009 oValid  output  1  issued instruction fields are valid.
REQ-010 oOperation  output  4  opcode, iInstruction[27:24].
REQ-011 oDestination  output  8  iInstruction[23:16].
REQ-012 oSourceAddr1  output  8  iInstruction[15:8].
REQ-013 oSourceAddr0  output  8  iInstruction[7:0].
REQ-014 oImmediate  output  16  iInstruction[15:0].

Function
REQ-015 Block SHALL implement states FETCH and DELAY.
REQ-016 In FETCH, iStall=0, non-NOP opcode: decoded fields SHALL register to outputs, oValid<=1, PC<=PC+1; issue latency one cycle after PC=A.
REQ-017 In FETCH, iStall=0, opcode NOP with 24-bit payload N: oValid<=0, PC<=PC+1, delay counter<=N, go DELAY.
REQ-018 In DELAY: oValid=0; counter decrements each cycle; when counter=0, go FETCH; total NOP cost = N+1 cycles (N=0 costs one cycle).
REQ-019 iStall=1 (no branch): PC, state, counter and all outputs SHALL hold; oValid unchanged.
REQ-020 iBranchTaken=1 SHALL override stall, NOP and DELAY: PC<=iBranchTarget, oValid<=0, state<=FETCH, counter<=0.
REQ-021 PC SHALL wrap 16'hFFFF -> 16'h0000.
REQ-022 Opcodes other than NOP (including LED and unknown values) SHALL be issued unmodified; no opcode checking.
REQ-023 oAddress SHALL equal PC register directly (no combinational path from inputs).

Reset
REQ-024 Reset low SHALL immediately force PC=RESET_PC, state=FETCH, counter=0, oValid=0, oOperation/oDestination/oSourceAddr1/oSourceAddr0/oImmediate=0.
REQ-025 Reset asserted mid-DELAY or mid-stall SHALL abandon operation; first fetch after release at RESET_PC.

Structure
REQ-026 Opcode constants (NOP, STO, ADD, LED, ...) and register names SHALL come from the shared definitions include; no local opcode literals.
REQ-027 Field bit positions (opcode 27:24, dest 23:16, src1 15:8, src0 7:0) SHALL be defined once as constants in the shared definitions include.
REQ-028 One sub-module is natural: nop_delay_counter (24-bit loadable down-counter with zero flag); all else in instruction_fetch.

Verification
REQ-029 Release reset, ROM {STO,R7,16'd1} at 0: oAddress=0 first cycle; next cycle oValid=1, oOperation=STO, oDestination=R7, oImmediate=1, oAddress=1.
REQ-030 NOP payload 24'd3 at address 0: oValid=0 for 4 cycles, then instruction at address 1 issued; oAddress=1 throughout delay.
REQ-031 iStall=1 for 5 cycles after ADD,R4,R5,R3 issued: outputs and oAddress frozen, oValid=1; issue resumes the cycle after iStall drops.
REQ-032 iBranchTaken=1, iBranchTarget=16'h0010 during DELAY with iStall=1: next cycle oAddress=16'h0010, oValid=0, DELAY abandoned.
REQ-033 RESET_PC=16'hFFFF, non-NOP at FFFF: after issue oAddress=16'h0000.
REQ-034 Reset pulsed low mid-NOP (payload 24'd4000): outputs zero asynchronously; after release fetch restarts at RESET_PC.
